morse_keyer_ctrl: RTL and testbench

Sequences Morse keying for one letter at a time. Accepts an encoded letter over a valid/ready handshake and drives a tone-enable line. Element durations are counted in dot units, timed from an internal unit-tick enable rather than a divided clock. Sits between the character encoder upstream and the tone/LED output stage downstream.

---
 rtl/morse_pkg.sv | 25 ++
 rtl/unit_tick_gen.sv | 32 +++
 rtl/morse_keyer_ctrl.sv | 123 ++++++++++++
 tb/tb_morse_keyer_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse keyer: FSM states, element/gap lengths in dot
// units, and the letter-size limit.
package morse_pkg;

   localparam int MAX_ELEMS = 6;

   localparam logic [2:0] DOT_UNITS        = 3'd1;
   localparam logic [2:0] DASH_UNITS       = 3'd3;
   localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
   localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
   localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      MARK       = 3'd1,
      GAP        = 3'd2,
      LETTER_GAP = 3'd3,
      WORD_GAP   = 3'd4
   } state_t;

   function automatic logic [2:0] elem_units(input logic is_dash);
      return is_dash ? DASH_UNITS : DOT_UNITS;
   endfunction

endpackage

// File: rtl/unit_tick_gen.sv
// Dot-unit timebase: a single-cycle enable every UNIT_CYCLES clocks, restartable
// so that each keying phase begins on a fresh unit boundary.
module unit_tick_gen #(
   parameter int UNIT_CYCLES = 1250,
   parameter int TICK_WIDTH  = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   output logic o_tick
);

   localparam logic [TICK_WIDTH-1:0] TERMINAL = TICK_WIDTH'(UNIT_CYCLES - 1);

   logic [TICK_WIDTH-1:0] r_count;

   // Free-running unit counter, restarted by i_clear.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (r_count == TERMINAL) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + TICK_WIDTH'(1);
      end
   end

   assign o_tick = (r_count == TERMINAL);

endmodule

// File: rtl/morse_keyer_ctrl.sv
// Keys one Morse letter (or a word space) per handshake, timing every mark and
// gap in whole dot units from unit_tick_gen.
module morse_keyer_ctrl #(
   parameter int UNIT_CYCLES = 1250,
   parameter int TICK_WIDTH  = 16,
   parameter int MAX_ELEMS   = morse_pkg::MAX_ELEMS
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [2:0]           i_len,
   input  logic [MAX_ELEMS-1:0] i_pattern,
   output logic                 o_key,
   output logic                 o_busy,
   output logic                 o_done
);

   import morse_pkg::*;

   state_t                r_state;
   logic [2:0]            r_units;
   logic [2:0]            r_len;
   logic [2:0]            r_index;
   logic [MAX_ELEMS-1:0]  r_pattern;
   logic                  r_key;
   logic                  r_done;

   logic                  w_tick;
   logic                  w_accept;
   logic                  w_last_unit;
   logic                  w_clear;
   logic [2:0]            w_len_clamped;

   assign o_ready       = (r_state == IDLE);
   assign o_busy        = (r_state != IDLE);
   assign o_key         = r_key;
   assign o_done        = r_done;
   assign w_accept      = i_valid && o_ready;
   assign w_last_unit   = w_tick && (r_units == 3'd1) && (r_state != IDLE);
   assign w_clear       = w_accept || w_last_unit;
   assign w_len_clamped = (i_len > 3'(MAX_ELEMS)) ? 3'(MAX_ELEMS) : i_len;

   unit_tick_gen #(
      .UNIT_CYCLES (UNIT_CYCLES),
      .TICK_WIDTH  (TICK_WIDTH)
   ) u_tick (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   // Keying FSM; every phase loads its unit count and counts it down on ticks.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_units   <= 3'd0;
         r_len     <= 3'd0;
         r_index   <= 3'd0;
         r_pattern <= '0;
         r_key     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_len     <= w_len_clamped;
                  r_pattern <= i_pattern;
                  r_index   <= 3'd0;
                  if (w_len_clamped == 3'd0) begin
                     r_state <= WORD_GAP;
                     r_units <= WORD_EXTRA_UNITS;
                     r_key   <= 1'b0;
                  end else begin
                     r_state <= MARK;
                     r_units <= elem_units(i_pattern[0]);
                     r_key   <= 1'b1;
                  end
               end
            end
            MARK: begin
               if (w_last_unit) begin
                  r_key <= 1'b0;
                  if (r_index == r_len - 3'd1) begin
                     r_state <= LETTER_GAP;
                     r_units <= LETTER_GAP_UNITS;
                  end else begin
                     r_state <= GAP;
                     r_units <= ELEM_GAP_UNITS;
                     r_index <= r_index + 3'd1;
                  end
               end else if (w_tick) begin
                  r_units <= r_units - 3'd1;
               end
            end
            GAP: begin
               if (w_last_unit) begin
                  r_state <= MARK;
                  r_units <= elem_units(r_pattern[r_index]);
                  r_key   <= 1'b1;
               end else if (w_tick) begin
                  r_units <= r_units - 3'd1;
               end
            end
            LETTER_GAP, WORD_GAP: begin
               if (w_last_unit) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end else if (w_tick) begin
                  r_units <= r_units - 3'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_key   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Self-checking bench for morse_keyer_ctrl: a cycle-level keying waveform model
// built from Morse timing rules, checked every clock against the DUT.
module tb_morse_keyer_ctrl;

   localparam int UC = 4;
   localparam int TW = 16;
   localparam int ME = 6;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid = 1'b0;
   logic [2:0]    len   = 3'd0;
   logic [ME-1:0] pat   = '0;
   logic          ready;
   logic          key;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;
   bit exp_q[$];

   morse_keyer_ctrl #(
      .UNIT_CYCLES (UC),
      .TICK_WIDTH  (TW),
      .MAX_ELEMS   (ME)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_valid   (valid),
      .o_ready   (ready),
      .i_len     (len),
      .i_pattern (pat),
      .o_key     (key),
      .o_busy    (busy),
      .o_done    (done)
   );

   always #5 clk = ~clk;

   // Expected o_key per cycle from the cycle after accept up to (not including) o_done.
   function automatic void build_model(input int l, input int p);
      int n;
      n = (l > ME) ? ME : l;
      exp_q.delete();
      if (n == 0) begin
         for (int c = 0; c < 4 * UC; c++) exp_q.push_back(1'b0);
      end
      for (int e = 0; e < n; e++) begin
         int u;
         u = (((p >> e) & 1) != 0) ? 3 : 1;
         for (int c = 0; c < u * UC; c++) exp_q.push_back(1'b1);
         if (e < n - 1) begin
            for (int c = 0; c < UC; c++) exp_q.push_back(1'b0);
         end
      end
      if (n > 0) begin
         for (int c = 0; c < 3 * UC; c++) exp_q.push_back(1'b0);
      end
   endfunction

   task automatic drive_letter(input int l, input int p, input bit noise, input string tag);
      n_checks++;
      if (ready !== 1'b1) begin
         n_errors++;
         $display("FAIL %s ready_before_accept: got %b want 1", tag, ready);
      end
      valid = 1'b1;
      len   = l[2:0];
      pat   = p[ME-1:0];
      build_model(l, p);
      @(negedge clk);
      valid = 1'b0;
      for (int c = 0; c < exp_q.size(); c++) begin
         n_checks++;
         if (key !== exp_q[c] || busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got key=%b busy=%b done=%b ready=%b want key=%b busy=1 done=0 ready=0",
                     tag, c, key, busy, done, ready, exp_q[c]);
         end
         if (noise) begin
            valid = 1'($urandom);
            len   = 3'($urandom);
            pat   = ME'($urandom);
         end
         @(negedge clk);
      end
      valid = 1'b0;
      n_checks++;
      if (done !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || key !== 1'b0) begin
         n_errors++;
         $display("FAIL %s done_cycle %0d: got done=%b ready=%b busy=%b key=%b want 1 1 0 0",
                  tag, exp_q.size(), done, ready, busy, key);
      end
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || key !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s idle %0d: got done=%b key=%b ready=%b busy=%b want 0 0 1 0",
                     tag, c, done, key, ready, busy);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (key !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_state: got key=%b busy=%b done=%b ready=%b want 0 0 0 1",
                  key, busy, done, ready);
      end
      valid = 1'b0;
      rst_n = 1'b1;
      idle_cycles(2, "after_reset");
   endtask

   task automatic test_letter_a();
      drive_letter(2, 6'b000010, 1'b0, "letter_A");
      idle_cycles(2, "after_A");
   endtask

   task automatic test_back_to_back();
      drive_letter(1, 6'b000000, 1'b0, "letter_E");
      drive_letter(0, 6'b000000, 1'b0, "word_space");
      idle_cycles(1, "after_word");
   endtask

   task automatic test_busy_ignore();
      drive_letter(3, 6'b000111, 1'b1, "letter_O_noise");
      idle_cycles(1, "after_O");
   endtask

   task automatic test_clamp();
      drive_letter(7, 6'b101010, 1'b0, "clamp_len7");
      idle_cycles(1, "after_clamp");
   endtask

   task automatic test_reset_mid_dash();
      valid = 1'b1;
      len   = 3'd1;
      pat   = 6'b000001;
      @(negedge clk);
      valid = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (key !== 1'b1 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_dash_T: got key=%b busy=%b want 1 1", key, busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (key !== 1'b0 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid_dash: got key=%b busy=%b ready=%b done=%b want 0 0 1 0",
                  key, busy, ready, done);
      end
      rst_n = 1'b1;
      idle_cycles(20, "post_reset_quiet");
      drive_letter(1, 6'b000000, 1'b0, "fresh_E");
      idle_cycles(1, "after_fresh_E");
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         int l;
         int p;
         bit nz;
         l  = int'($urandom_range(0, 7));
         p  = int'($urandom_range(0, 63));
         nz = 1'($urandom);
         drive_letter(l, p, nz, $sformatf("rand%0d_len%0d_pat%0h", i, l, p));
         idle_cycles(int'($urandom_range(0, 2)), "rand_idle");
      end
   endtask

   initial begin
      test_reset();
      test_letter_a();
      test_back_to_back();
      test_busy_ignore();
      test_clamp();
      test_reset_mid_dash();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
